acc_alu_seq: RTL and testbench



---
 rtl/acc_alu_pkg.sv | 31 +++
 rtl/acc_alu_iter.sv | 105 ++++++++++
 rtl/acc_alu_seq.sv | 148 ++++++++++++++
 tb/tb_acc_alu_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential accumulator ALU.
package acc_alu_pkg;

    typedef enum logic [3:0] {
        OP_LD  = 4'b0000,
        OP_ST  = 4'b0001,
        OP_NOP = 4'b0010,
        OP_MOF = 4'b0011,
        OP_AND = 4'b0100,
        OP_OR  = 4'b0101,
        OP_XOR = 4'b0110,
        OP_ADC = 4'b0111,
        OP_SBB = 4'b1000,
        OP_LSL = 4'b1001,
        OP_LSR = 4'b1010,
        OP_CMP = 4'b1011,
        OP_BEQ = 4'b1100,
        OP_BNE = 4'b1101,
        OP_MUL = 4'b1110
    } alu_op_t;

    // Decodes as NOP in every build.
    localparam logic [3:0] OP_RESERVED = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } alu_state_t;

endpackage

// File: rtl/acc_alu_iter.sv
// Iteration engine: counter plus one-bit shift or shift-add step per cycle.
// Multiply datapath only present when ACC_ALU_MUL_EN is defined.
module acc_alu_iter
    import acc_alu_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned SHW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  alu_op_t      op,
    input  logic [W-1:0] operand,
    input  logic [W-1:0] acc_in,
    input  logic         carry_in,
    output logic         last,
    output logic [W-1:0] next_acc,
    output logic [W-1:0] next_hi,
    output logic         next_carry
);

    localparam logic [W-1:0]   WOp  = W'(W);
    localparam logic [SHW-1:0] WCnt = SHW'(W);

    logic [SHW-1:0] cnt_q, load_cnt;
    alu_op_t        op_q;
    logic [W-1:0]   work_q;
    logic           carry_q;
`ifdef ACC_ALU_MUL_EN
    logic [W-1:0]   hi_q, mcand_q;
    logic [W:0]     sum;
`endif

    // Shift distance saturates at W; multiply always runs W steps.
    always_comb begin
        load_cnt = (operand >= WOp) ? WCnt : operand[SHW-1:0];
`ifdef ACC_ALU_MUL_EN
        if (op == OP_MUL) begin
            load_cnt = WCnt;
        end
`endif
    end

    assign last = (cnt_q == SHW'(1));

    always_comb begin
        next_acc   = work_q;
        next_hi    = '0;
        next_carry = carry_q;
`ifdef ACC_ALU_MUL_EN
        next_hi = hi_q;
        sum     = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
`endif
        case (op_q)
            OP_LSL: begin
                next_acc   = {work_q[W-2:0], 1'b0};
                next_carry = work_q[W-1];
            end
            OP_LSR: begin
                next_acc   = {1'b0, work_q[W-1:1]};
                next_carry = work_q[0];
            end
`ifdef ACC_ALU_MUL_EN
            // {hi, lo} holds partial product and remaining multiplier bits.
            OP_MUL: begin
                next_hi    = sum[W:1];
                next_acc   = {sum[0], work_q[W-1:1]};
                next_carry = (sum[W:1] != '0);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            work_q  <= '0;
            carry_q <= 1'b0;
`ifdef ACC_ALU_MUL_EN
            hi_q    <= '0;
            mcand_q <= '0;
`endif
        end else if (load) begin
            cnt_q   <= load_cnt;
            op_q    <= op;
            work_q  <= acc_in;
            carry_q <= carry_in;
`ifdef ACC_ALU_MUL_EN
            hi_q    <= '0;
            mcand_q <= operand;
`endif
        end else if (step) begin
            cnt_q   <= cnt_q - SHW'(1);
            work_q  <= next_acc;
            carry_q <= next_carry;
`ifdef ACC_ALU_MUL_EN
            hi_q    <= next_hi;
`endif
        end
    end

endmodule

// File: rtl/acc_alu_seq.sv
// Sequential accumulator ALU: FSM, start/done handshake and single-cycle ops.
// Define ACC_ALU_MUL_EN to enable the iterative multiply (opcode 1110).
module acc_alu_seq
    import acc_alu_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned SHW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   alu_cmd,
    input  logic [W-1:0] in_reg,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] acc,
    output logic         carry,
    output logic         zero,
    output logic         branch_taken,
    output logic [W-1:0] prod_hi
);

    alu_state_t   state_q, state_d;
    alu_op_t      cmd, op_q;
    logic         accept, is_iter, busy_d, done_d;
    logic [W-1:0] acc_d, prod_hi_d;
    logic         carry_d, branch_d;
    logic [W:0]   sum_w, diff_w;
    logic         it_last, it_carry;
    logic [W-1:0] it_acc, it_hi;

    assign cmd    = alu_op_t'(alu_cmd);
    assign accept = (state_q == IDLE) && start;
    assign zero   = (acc == '0);
    assign sum_w  = {1'b0, acc} + {1'b0, in_reg} + (W+1)'(carry);
    assign diff_w = {1'b0, acc} - {1'b0, in_reg} - (W+1)'(carry);

    // A zero-length shift skips EXEC and completes like a single-cycle op.
    always_comb begin
        is_iter = 1'b0;
        case (cmd)
            OP_LSL, OP_LSR: is_iter = (in_reg != '0);
`ifdef ACC_ALU_MUL_EN
            OP_MUL:         is_iter = 1'b1;
`endif
            default:        is_iter = 1'b0;
        endcase
    end

    acc_alu_iter #(
        .W   (W),
        .SHW (SHW)
    ) u_iter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept && is_iter),
        .step       (state_q == EXEC),
        .op         (cmd),
        .operand    (in_reg),
        .acc_in     (acc),
        .carry_in   (carry),
        .last       (it_last),
        .next_acc   (it_acc),
        .next_hi    (it_hi),
        .next_carry (it_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = is_iter ? EXEC : DONE;
            EXEC:    if (it_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Results commit on the edge that enters DONE.
    always_comb begin
        acc_d     = acc;
        carry_d   = carry;
        branch_d  = branch_taken;
        prod_hi_d = prod_hi;
        if (accept) begin
            branch_d = 1'b0;
            case (cmd)
                OP_LD, OP_MOF: acc_d = in_reg;
                OP_AND:        acc_d = acc & in_reg;
                OP_OR:         acc_d = acc | in_reg;
                OP_XOR:        acc_d = acc ^ in_reg;
                OP_ADC: begin
                    acc_d   = sum_w[W-1:0];
                    carry_d = sum_w[W];
                end
                OP_SBB: begin
                    acc_d   = diff_w[W-1:0];
                    carry_d = diff_w[W];
                end
                OP_CMP:        acc_d = (acc < in_reg) ? W'(1) : '0;
                OP_BEQ:        branch_d = zero;
                OP_BNE:        branch_d = ~zero;
                default: ;
            endcase
        end else if (state_q == EXEC && it_last) begin
            acc_d   = it_acc;
            carry_d = it_carry;
            if (op_q == OP_MUL) begin
                prod_hi_d = it_hi;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q         <= OP_NOP;
            acc          <= '0;
            carry        <= 1'b0;
            branch_taken <= 1'b0;
            prod_hi      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= cmd;
            end
            acc          <= acc_d;
            carry        <= carry_d;
            branch_taken <= branch_d;
            prod_hi      <= prod_hi_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed and random checks of acc_alu_seq against an arithmetic reference model.
module tb_acc_alu_seq;

    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [3:0]   alu_cmd;
    logic [W-1:0] in_reg;
    logic         busy, done, carry, zero, branch_taken;
    logic [W-1:0] acc, prod_hi;

    int errors = 0;
    int checks = 0;
    int m_acc, m_carry, m_hi, m_br;

    always #5 clk = ~clk;

    acc_alu_seq #(.W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .alu_cmd      (alu_cmd),
        .in_reg       (in_reg),
        .busy         (busy),
        .done         (done),
        .acc          (acc),
        .carry        (carry),
        .zero         (zero),
        .branch_taken (branch_taken),
        .prod_hi      (prod_hi)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: applies one command to the architectural state, returns latency.
    task automatic model_exec(input int cmd, input int v, output int lat);
        int s, n;
        lat  = 2;
        m_br = 0;
        case (cmd)
            0, 3: m_acc = v;
            4:    m_acc = m_acc & v;
            5:    m_acc = m_acc | v;
            6:    m_acc = m_acc ^ v;
            7: begin
                s = m_acc + v + m_carry;
                m_acc = s % MOD;
                m_carry = s / MOD;
            end
            8: begin
                s = m_acc - v - m_carry;
                m_carry = (s < 0) ? 1 : 0;
                m_acc = (s < 0) ? s + MOD : s;
            end
            9, 10: begin
                n = (v > W) ? W : v;
                lat = 2 + n;
                for (int i = 0; i < n; i++) begin
                    if (cmd == 9) begin
                        m_carry = m_acc / (MOD / 2);
                        m_acc = (m_acc * 2) % MOD;
                    end else begin
                        m_carry = m_acc % 2;
                        m_acc = m_acc / 2;
                    end
                end
            end
            11: m_acc = (m_acc < v) ? 1 : 0;
            12: m_br = (m_acc == 0) ? 1 : 0;
            13: m_br = (m_acc != 0) ? 1 : 0;
`ifdef ACC_ALU_MUL_EN
            14: begin
                s = m_acc * v;
                m_acc = s % MOD;
                m_hi = s / MOD;
                m_carry = (m_hi != 0) ? 1 : 0;
                lat = 2 + W;
            end
`endif
            default: ;
        endcase
    endtask

    // Entered and left at a negedge inside an IDLE cycle; that cycle is cycle 1.
    task automatic run_cmd(input int cmd, input int v);
        int lat, cyc;
        bit seen;
        model_exec(cmd, v, lat);
        start   = 1'b1;
        alu_cmd = cmd[3:0];
        in_reg  = v[W-1:0];
        @(negedge clk);
        start = 1'b0;
        cyc   = 2;
        check("busy_after_start", busy, 1);
        seen = 0;
        for (int k = 0; k < W + 6; k++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("latency cmd=%0h v=%0d", cmd, v), seen ? cyc : -1, lat);
        check($sformatf("acc cmd=%0h v=%0d", cmd, v), acc, m_acc);
        check("carry", carry, m_carry);
        check("zero", zero, (m_acc == 0) ? 1 : 0);
        check("branch_taken", branch_taken, m_br);
        check("prod_hi", prod_hi, m_hi);
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        int lat, ndone, first;
        reset = 1'b1; start = 1'b0; alu_cmd = '0; in_reg = '0;
        m_acc = 0; m_carry = 0; m_hi = 0; m_br = 0;
        repeat (2) @(negedge clk);
        check("rst_acc", acc, 0);
        check("rst_carry", carry, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_branch", branch_taken, 0);
        check("rst_prod_hi", prod_hi, 0);
        check("rst_zero", zero, 1);
        reset = 1'b0;
        @(negedge clk);

        // Reset during the third EXEC cycle of LSL by 5.
        run_cmd(0, 8'h01);
        start = 1'b1; alu_cmd = 4'h9; in_reg = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_acc", acc, 0);
        check("midrst_carry", carry, 0);
        check("midrst_busy", busy, 0);
        m_acc = 0; m_carry = 0; m_hi = 0; m_br = 0;
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("midrst_no_done", ndone, 0);

        // ADC chain
        run_cmd(0, 8'hF0);
        run_cmd(7, 8'h20);
        run_cmd(7, 8'h00);
        // Shifts with clamp and zero length
        run_cmd(0, 8'h81);
        run_cmd(9, 1);
        run_cmd(10, 200);
        run_cmd(9, 0);
        // Branch and compare
        run_cmd(0, 0);
        run_cmd(12, 0);
        run_cmd(13, 0);
        run_cmd(0, 3);
        run_cmd(11, 7);
        // Multiply (NOP when the multiplier is not built) and reserved opcode
        run_cmd(0, 8'hFF);
        run_cmd(14, 8'hFF);
        run_cmd(15, 8'h12);
        run_cmd(8, 8'h05);

        // Start held through a 5-cycle shift; a new command shown in the done cycle.
        run_cmd(0, 3);
        model_exec(9, 5, lat);
        start = 1'b1; alu_cmd = 4'h9; in_reg = 8'd5;
        ndone = 0; first = -1;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = c;
                alu_cmd = 4'h0;
                in_reg  = 8'h5A;
            end
        end
        check("hs_done_count", ndone, 1);
        check("hs_done_cycle", first, lat);
        check("hs_acc", acc, m_acc);
        check("hs_carry", carry, m_carry);
        check("hs_idle_cycle", busy, 0);
        model_exec(0, 8'h5A, lat);
        @(negedge clk);
        start = 1'b0;
        check("hs_second_done", done, 1);
        check("hs_second_acc", acc, m_acc);
        for (int c = 0; c < W + 4 && busy !== 1'b0; c++) @(negedge clk);
        @(negedge clk);

        // Random commands
        for (int i = 0; i < 40; i++) begin
            int cmd, v;
            cmd = $urandom_range(0, 15);
            v   = $urandom_range(0, MOD - 1);
            if ((cmd == 9 || cmd == 10) && ($urandom_range(0, 1) == 1)) begin
                v = $urandom_range(0, W + 2);
            end
            run_cmd(cmd, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
